// File: rtl/user_pulse_seq_pkg.sv
// user_pulse_seq_pkg: shared state encoding and default field widths for the pulse sequencer.
package user_pulse_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_CNT_W = 16;
  localparam int DEF_REP_W = 8;
endpackage

// File: rtl/user_pulse_seq_next.sv
// user_pulse_seq_next: finds the lowest valid segment above cur, or the lowest overall when first is set.
module user_pulse_seq_next #(
  parameter int NUM_SEG = 4,
  parameter int SEG_W   = $clog2(NUM_SEG)
) (
  input  logic [NUM_SEG-1:0] valid,
  input  logic [SEG_W-1:0]   cur,
  input  logic               first,
  output logic               found,
  output logic [SEG_W-1:0]   next_idx
);
  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int k = NUM_SEG - 1; k >= 0; k--) begin
      if (valid[k] && (first || k > int'(cur))) begin
        found    = 1'b1;
        next_idx = SEG_W'(k);
      end
    end
  end
endmodule

// File: rtl/user_pulse_seq.sv
// user_pulse_seq: multi-segment programmable pulse sequencer with skip of empty segments.
// Define USER_PULSE_SEQ_LOOP_EN to build the loop_i restart path.
module user_pulse_seq
  import user_pulse_seq_pkg::*;
#(
  parameter int NUM_SEG = 4,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int REP_W   = DEF_REP_W,
  parameter int SEG_W   = $clog2(NUM_SEG)
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           stop_i,
  input  logic                           loop_i,
  input  logic [NUM_SEG-1:0][CNT_W-1:0]  seg_period_i,
  input  logic [NUM_SEG-1:0][CNT_W-1:0]  seg_high_i,
  input  logic [NUM_SEG-1:0][REP_W-1:0]  seg_rep_i,
  input  logic [NUM_SEG-1:0]             seg_inv_i,
  output logic                           pulse_o,
  output logic                           busy_o,
  output logic [SEG_W-1:0]               seg_o,
  output logic                           done_o
);
  state_t             state_q, state_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [CNT_W-1:0]   cyc_q, cyc_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [NUM_SEG-1:0] valid;
  logic               first_found, next_found, wrap;
  logic [SEG_W-1:0]   first_idx, next_idx;
  logic [CNT_W-1:0]   per, high;
  logic [REP_W-1:0]   rep;
  logic               period_end, seg_end;

  always_comb begin
    valid = '0;
    for (int k = 0; k < NUM_SEG; k++) valid[k] = |seg_rep_i[k] && |seg_period_i[k];
  end

  user_pulse_seq_next #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W)) u_first (
    .valid(valid), .cur(seg_q), .first(1'b1), .found(first_found), .next_idx(first_idx)
  );

  user_pulse_seq_next #(.NUM_SEG(NUM_SEG), .SEG_W(SEG_W)) u_next (
    .valid(valid), .cur(seg_q), .first(1'b0), .found(next_found), .next_idx(next_idx)
  );

`ifdef USER_PULSE_SEQ_LOOP_EN
  assign wrap = loop_i;
`else
  logic unused_loop;
  assign unused_loop = loop_i;
  assign wrap = 1'b0;
`endif

  assign per        = seg_period_i[seg_q];
  assign high       = seg_high_i[seg_q];
  assign rep        = seg_rep_i[seg_q];
  assign period_end = cyc_q == per - CNT_W'(1);
  assign seg_end    = period_end && rep_q == rep - REP_W'(1);

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cyc_d   = cyc_q;
    rep_d   = rep_q;
    if (stop_i) begin
      state_d = IDLE;
      cyc_d   = '0;
      rep_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_d = first_found ? RUN : DONE;
          seg_d   = first_found ? first_idx : seg_q;
          cyc_d   = '0;
          rep_d   = '0;
        end
        RUN: begin
          cyc_d = period_end ? '0 : cyc_q + CNT_W'(1);
          rep_d = seg_end ? '0 : period_end ? rep_q + REP_W'(1) : rep_q;
          if (seg_end) begin
            seg_d   = next_found ? next_idx : wrap ? first_idx : seg_q;
            state_d = (next_found || wrap) ? RUN : DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      seg_q   <= '0;
      cyc_q   <= '0;
      rep_q   <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cyc_q   <= cyc_d;
      rep_q   <= rep_d;
    end
  end

  assign busy_o  = state_q == RUN;
  assign done_o  = state_q == DONE;
  assign seg_o   = seg_q;
  assign pulse_o = busy_o && ((cyc_q < high) ^ seg_inv_i[seg_q]);
endmodule
